// File: rtl/neuron_backprop.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : neuron_backprop
//  Purpose  : Backward-pass engine for one 3-input sigmoid neuron (Q8.8).
//             Computes delta = err*y*(1-y), SGD-updated weights/bias
//             (step = grad >>> LR_SHIFT) and the error propagated to each
//             input using the pre-update weights.
//  Config   : define BP_SATURATE_EN to saturate every 16-bit narrowing;
//             leave it undefined for plain wrap-around truncation.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_backprop #(
   parameter int LR_SHIFT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] x0,
   input  logic [15:0] x1,
   input  logic [15:0] x2,
   input  logic [15:0] y,
   input  logic [15:0] err_in,
   input  logic [15:0] w0_in,
   input  logic [15:0] w1_in,
   input  logic [15:0] w2_in,
   input  logic [15:0] b_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] w0_out,
   output logic [15:0] w1_out,
   output logic [15:0] w2_out,
   output logic [15:0] b_out,
   output logic [15:0] delta_out,
   output logic [15:0] err_back0,
   output logic [15:0] err_back1,
   output logic [15:0] err_back2
);

`ifdef BP_SATURATE_EN
   localparam bit c_SAT = 1'b1;
`else
   localparam bit c_SAT = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DERIV = 3'd1,
      S_DELTA = 3'd2,
      S_UPD   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   logic [1:0]  r_idx;
   logic [15:0] r_x0, r_x1, r_x2, r_y, r_err;
   logic [15:0] r_w0, r_w1, r_w2, r_b;
   logic [15:0] r_deriv, r_delta;
   logic [15:0] r_wn0, r_wn1, r_wn2;
   logic [15:0] r_eb0, r_eb1, r_eb2;

   logic [8:0]         w_yc;
   logic [17:0]        w_dprod;
   logic [15:0]        w_deriv;
   logic [15:0]        w_delta;
   logic [15:0]        w_xk, w_wk;
   logic signed [15:0] w_grad, w_step;
   logic [15:0]        w_wnew, w_eb;

   // Q16.16 product narrowed to Q8.8: floor shift by 8, then wrap or saturate.
   function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] ae, be, p, ps;
      logic               ovf;
      ae  = {{16{a[15]}}, a};
      be  = {{16{b[15]}}, b};
      p   = ae * be;
      ps  = p >>> 8;
      ovf = (ps[31:15] != {17{ps[15]}});
      if (c_SAT && ovf)
         qmul = ps[31] ? 16'h8000 : 16'h7FFF;
      else
         qmul = ps[15:0];
   endfunction

   // 17-bit signed difference narrowed back to 16 bits.
   function automatic logic [15:0] ssub(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] d;
      d = {a[15], a} - {b[15], b};
      if (c_SAT && (d[16] != d[15]))
         ssub = d[16] ? 16'h8000 : 16'h7FFF;
      else
         ssub = d[15:0];
   endfunction

   // Datapath: derivative, delta and the per-index update for the current slot.
   always_comb begin
      w_yc = 9'd0;
      if (!r_y[15]) begin
         if (r_y > 16'h0100)
            w_yc = 9'h100;
         else
            w_yc = r_y[8:0];
      end
      w_dprod = {9'd0, w_yc} * (18'h00100 - {9'd0, w_yc});
      w_deriv = 16'(w_dprod >> 8);
      w_delta = qmul(r_err, r_deriv);

      w_xk = r_x0;
      w_wk = r_w0;
      case (r_idx)
         2'd0:    begin w_xk = r_x0;    w_wk = r_w0; end
         2'd1:    begin w_xk = r_x1;    w_wk = r_w1; end
         2'd2:    begin w_xk = r_x2;    w_wk = r_w2; end
         default: begin w_xk = 16'h0100; w_wk = r_b;  end
      endcase
      w_grad = qmul(r_delta, w_xk);
      w_step = w_grad >>> LR_SHIFT;
      w_wnew = ssub(w_wk, w_step);
      w_eb   = qmul(r_delta, w_wk);
   end

   // Sequencer: latch operands, step through derivative/delta/updates, publish on DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= 2'd0;
         r_x0      <= 16'd0; r_x1 <= 16'd0; r_x2 <= 16'd0;
         r_y       <= 16'd0; r_err <= 16'd0;
         r_w0      <= 16'd0; r_w1 <= 16'd0; r_w2 <= 16'd0; r_b <= 16'd0;
         r_deriv   <= 16'd0; r_delta <= 16'd0;
         r_wn0     <= 16'd0; r_wn1 <= 16'd0; r_wn2 <= 16'd0;
         r_eb0     <= 16'd0; r_eb1 <= 16'd0; r_eb2 <= 16'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         w0_out    <= 16'd0; w1_out <= 16'd0; w2_out <= 16'd0; b_out <= 16'd0;
         delta_out <= 16'd0;
         err_back0 <= 16'd0; err_back1 <= 16'd0; err_back2 <= 16'd0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x0    <= x0;    r_x1 <= x1;    r_x2 <= x2;
                  r_y     <= y;     r_err <= err_in;
                  r_w0    <= w0_in; r_w1 <= w1_in; r_w2 <= w2_in; r_b <= b_in;
                  busy    <= 1'b1;
                  r_state <= S_DERIV;
               end
            end
            S_DERIV: begin
               r_deriv <= w_deriv;
               r_state <= S_DELTA;
            end
            S_DELTA: begin
               r_delta <= w_delta;
               r_idx   <= 2'd0;
               r_state <= S_UPD;
            end
            S_UPD: begin
               r_idx <= r_idx + 2'd1;
               case (r_idx)
                  2'd0: begin r_wn0 <= w_wnew; r_eb0 <= w_eb; end
                  2'd1: begin r_wn1 <= w_wnew; r_eb1 <= w_eb; end
                  2'd2: begin r_wn2 <= w_wnew; r_eb2 <= w_eb; end
                  default: begin
                     // Bias slot: all results become visible together.
                     w0_out    <= r_wn0;
                     w1_out    <= r_wn1;
                     w2_out    <= r_wn2;
                     b_out     <= w_wnew;
                     delta_out <= r_delta;
                     err_back0 <= r_eb0;
                     err_back1 <= r_eb1;
                     err_back2 <= r_eb2;
                     done      <= 1'b1;
                     r_state   <= S_DONE;
                  end
               endcase
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_neuron_backprop.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_backprop
//  Purpose  : Self-checking bench for neuron_backprop against an integer
//             reference model of the backward-pass arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_backprop;
   localparam int LR = 2;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] x0, x1, x2, y, err_in, w0_in, w1_in, w2_in, b_in;
   logic        busy, done;
   logic [15:0] w0_out, w1_out, w2_out, b_out, delta_out;
   logic [15:0] err_back0, err_back1, err_back2;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [15:0] x0, x1, x2, y, err, w0, w1, w2, b;
   } vec_t;

   typedef struct packed {
      logic [15:0] w0, w1, w2, b, delta, e0, e1, e2;
   } res_t;

   res_t prev;

   neuron_backprop #(.LR_SHIFT(LR)) dut (
      .clk(clk), .rst(rst), .start(start),
      .x0(x0), .x1(x1), .x2(x2), .y(y), .err_in(err_in),
      .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in), .b_in(b_in),
      .busy(busy), .done(done),
      .w0_out(w0_out), .w1_out(w1_out), .w2_out(w2_out), .b_out(b_out),
      .delta_out(delta_out),
      .err_back0(err_back0), .err_back1(err_back1), .err_back2(err_back2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) ----------------
   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic logic [15:0] nar(input int v);
`ifdef BP_SATURATE_EN
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
`endif
      return v[15:0];
   endfunction

   function automatic logic [15:0] qm(input int a, input int b);
      int p;
      p = a * b;
      return nar(p >>> 8);
   endfunction

   function automatic res_t model(input vec_t v);
      res_t r;
      int yi, yc, deriv, d;
      int xs[4];
      int ws[4];
      logic [15:0] wn[4];
      yi = sx(v.y);
      yc = (yi < 0) ? 0 : ((yi > 256) ? 256 : yi);
      deriv = (yc * (256 - yc)) / 256;
      d = sx(qm(sx(v.err), deriv));
      xs[0] = sx(v.x0); xs[1] = sx(v.x1); xs[2] = sx(v.x2); xs[3] = 256;
      ws[0] = sx(v.w0); ws[1] = sx(v.w1); ws[2] = sx(v.w2); ws[3] = sx(v.b);
      for (int k = 0; k < 4; k++) begin
         int g;
         g = sx(qm(d, xs[k]));
         wn[k] = nar(ws[k] - (g >>> LR));
      end
      r.w0 = wn[0]; r.w1 = wn[1]; r.w2 = wn[2]; r.b = wn[3];
      r.delta = d[15:0];
      r.e0 = qm(d, ws[0]);
      r.e1 = qm(d, ws[1]);
      r.e2 = qm(d, ws[2]);
      return r;
   endfunction

   // ---------------- helpers ----------------
   function automatic res_t dut_res();
      res_t r;
      r = {w0_out, w1_out, w2_out, b_out, delta_out, err_back0, err_back1, err_back2};
      return r;
   endfunction

   task automatic check_res(input string tag, input res_t e);
      res_t r;
      r = dut_res();
      check({tag, ".w0"},    128'(r.w0),    128'(e.w0));
      check({tag, ".w1"},    128'(r.w1),    128'(e.w1));
      check({tag, ".w2"},    128'(r.w2),    128'(e.w2));
      check({tag, ".b"},     128'(r.b),     128'(e.b));
      check({tag, ".delta"}, 128'(r.delta), 128'(e.delta));
      check({tag, ".eb0"},   128'(r.e0),    128'(e.e0));
      check({tag, ".eb1"},   128'(r.e1),    128'(e.e1));
      check({tag, ".eb2"},   128'(r.e2),    128'(e.e2));
   endtask

   task automatic drive(input vec_t v);
      x0 = v.x0; x1 = v.x1; x2 = v.x2; y = v.y; err_in = v.err;
      w0_in = v.w0; w1_in = v.w1; w2_in = v.w2; b_in = v.b;
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v.x0 = 16'($urandom); v.x1 = 16'($urandom); v.x2 = 16'($urandom);
      v.y  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 256)) : 16'($urandom);
      v.err = 16'($urandom);
      v.w0 = 16'($urandom); v.w1 = 16'($urandom); v.w2 = 16'($urandom);
      v.b  = 16'($urandom);
      return v;
   endfunction

   // Starts one operation at the current negedge and returns 8 cycles later.
   task automatic run_vec(input string tag, input vec_t v);
      res_t e;
      int   cyc;
      bit   got;
      e = model(v);
      drive(v);
      start = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            drive(rand_vec());
            check({tag, ".busy"}, 128'(busy), 128'(1));
         end
         if (cyc == 3)
            check({tag, ".hold"}, 128'(dut_res()), 128'(prev));
         if (done)
            got = 1'b1;
      end
      check({tag, ".lat"}, 128'(cyc), 128'(7));
      if (got)
         check_res(tag, e);
      @(negedge clk);
      check({tag, ".pulse"}, 128'(done), 128'(0));
      check({tag, ".keep"}, 128'(dut_res()), 128'(e));
      prev = e;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t nom, v, v2;
      res_t e1;
      int   ndone;
      bit   seen;

      nom = '{x0: 16'h0100, x1: 16'h0000, x2: 16'h0080, y: 16'h0080, err: 16'h0100,
              w0: 16'h0100, w1: 16'h0040, w2: 16'h0000, b: 16'h0000};
      prev = '0;

      // Reset held with start asserted
      rst = 1'b1;
      start = 1'b1;
      drive(nom);
      repeat (3) begin
         @(negedge clk);
         check("rst.busy", 128'(busy), 128'(0));
         check("rst.done", 128'(done), 128'(0));
         check("rst.out", 128'(dut_res()), 128'(0));
      end
      rst = 1'b0;
      @(negedge clk);
      check("rst.rise", 128'(busy), 128'(1));
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("rst.run", 128'(seen), 128'(1));
      check_res("rst.res", model(nom));
      @(negedge clk);
      prev = model(nom);

      // Nominal vector with known results
      run_vec("nom", nom);
      check("nom.k_delta", 128'(delta_out), 128'(16'h0040));
      check("nom.k_w0",    128'(w0_out),    128'(16'h00F0));
      check("nom.k_w1",    128'(w1_out),    128'(16'h0040));
      check("nom.k_w2",    128'(w2_out),    128'(16'hFFF8));
      check("nom.k_b",     128'(b_out),     128'(16'hFFF0));
      check("nom.k_eb0",   128'(err_back0), 128'(16'h0040));
      check("nom.k_eb1",   128'(err_back1), 128'(16'h0010));
      check("nom.k_eb2",   128'(err_back2), 128'(16'h0000));

      // Clamp: y outside [0,1] gives zero derivative
      v = rand_vec();
      v.y = 16'h0180;
      run_vec("clamp_hi", v);
      check("clamp_hi.delta", 128'(delta_out), 128'(0));
      check("clamp_hi.w0", 128'(w0_out), 128'(v.w0));
      check("clamp_hi.b", 128'(b_out), 128'(v.b));
      check("clamp_hi.eb1", 128'(err_back1), 128'(0));
      v = rand_vec();
      v.y = 16'hFF00;
      run_vec("clamp_lo", v);
      check("clamp_lo.delta", 128'(delta_out), 128'(0));
      check("clamp_lo.w2", 128'(w2_out), 128'(v.w2));
      check("clamp_lo.eb0", 128'(err_back0), 128'(0));

      // Large products: saturate or wrap
      v = rand_vec();
      v.y = 16'h0080; v.err = 16'h7FFF; v.w1 = 16'h7FFF;
      run_vec("sat", v);
      check("sat.delta", 128'(delta_out), 128'(16'h1FFF));
`ifdef BP_SATURATE_EN
      check("sat.eb1", 128'(err_back1), 128'(16'h7FFF));
`else
      check("sat.eb1", 128'(err_back1), 128'(16'hFF60));
`endif

      // Second start while busy is ignored
      v  = rand_vec();
      v2 = rand_vec();
      e1 = model(v);
      drive(v);
      start = 1'b1;
      ndone = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 2) begin drive(v2); start = 1'b1; end
         if (k == 3) start = 1'b0;
         if (done) begin
            ndone++;
            check_res("dbl", e1);
         end
      end
      check("dbl.count", 128'(ndone), 128'(1));
      prev = e1;

      // Reset during the second update slot aborts the operation
      v = rand_vec();
      drive(v);
      start = 1'b1;
      ndone = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done) ndone++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort.busy", 128'(busy), 128'(0));
      check("abort.done", 128'(done), 128'(0));
      check("abort.out", 128'(dut_res()), 128'(0));
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort.nodone", 128'(ndone), 128'(0));
      check("abort.out2", 128'(dut_res()), 128'(0));
      prev = '0;
      run_vec("post_abort", rand_vec());

      // Back-to-back at minimum spacing
      for (int i = 0; i < 8; i++)
         run_vec($sformatf("b2b%0d", i), rand_vec());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
